memory_access_stage: RTL

- MEM stage of the 5-stage pipeline. Consumes the EX/MEM bundle: ALU result, store data and control bits. Produces the registered MEM/WB bundle that drives the GPR write port.
- Issues single-outstanding, variable-latency word accesses to the data memory through a request/ready handshake.
- Stalls upstream stages while an access is in flight.
- Filters misaligned accesses and accesses that time out, so neither ever writes the GPR.

---
 rtl/memory_access_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/memory_access_stage.sv
// MEM stage: issues single-outstanding data-memory word accesses and registers the MEM/WB bundle.
// Misaligned and timed-out accesses complete without a GPR write and raise a one-cycle flag.
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic        ex_memory_read,
  input  logic        ex_memory_write,
  input  logic        ex_memory_to_register,
  input  logic        ex_register_write,
  input  logic [4:0]  ex_write_address,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  output logic        stall,
  output logic        mem_request,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_read_data,
  output logic        wb_valid,
  output logic        wb_register_write,
  output logic [4:0]  wb_write_address,
  output logic [31:0] wb_write_data,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state_r;
  logic [COUNTER_WIDTH-1:0] count_r;
  logic                     mtr_r;
  logic                     reg_write_r;

  logic accept_s;
  logic mem_op_s;
  logic aligned_s;
  logic timeout_s;

  // Acceptance decode, timeout detect and the combinational upstream stall
  always_comb begin
    accept_s  = (state_r == IDLE) && ex_valid && !flush;
    mem_op_s  = ex_memory_read | ex_memory_write;
    aligned_s = (ex_alu_result[1:0] == 2'b00);
    timeout_s = (state_r == ACCESS) && !mem_ready && (count_r == LAST_COUNT);
    if (state_r == ACCESS) begin
      stall = !mem_ready;
    end else begin
      stall = accept_s && mem_op_s && aligned_s;
    end
  end

  // Access FSM with registered memory request and MEM/WB bundle
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state_r           <= IDLE;
      count_r           <= '0;
      mtr_r             <= 1'b0;
      reg_write_r       <= 1'b0;
      mem_request       <= 1'b0;
      mem_write         <= 1'b0;
      mem_address       <= 32'h0000_0000;
      mem_write_data    <= 32'h0000_0000;
      wb_valid          <= 1'b0;
      wb_register_write <= 1'b0;
      wb_write_address  <= 5'd0;
      wb_write_data     <= 32'h0000_0000;
      misaligned        <= 1'b0;
      bus_error         <= 1'b0;
    end else begin
      // Pulses and the write enable default low; only a completing instruction raises them
      wb_valid          <= 1'b0;
      wb_register_write <= 1'b0;
      misaligned        <= 1'b0;
      bus_error         <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wb_write_address <= ex_write_address;
            if (!mem_op_s) begin
              wb_valid          <= 1'b1;
              wb_register_write <= ex_register_write;
              wb_write_data     <= ex_alu_result;
            end else if (!aligned_s) begin
              wb_valid      <= 1'b1;
              misaligned    <= 1'b1;
              wb_write_data <= ex_alu_result;
            end else begin
              state_r        <= ACCESS;
              count_r        <= '0;
              mem_request    <= 1'b1;
              mem_write      <= ex_memory_write;
              mem_address    <= {ex_alu_result[31:2], 2'b00};
              mem_write_data <= ex_store_data;
              reg_write_r    <= ex_register_write & ~ex_memory_write;
              mtr_r          <= ex_memory_to_register;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state_r           <= IDLE;
            mem_request       <= 1'b0;
            wb_valid          <= 1'b1;
            wb_register_write <= reg_write_r;
            wb_write_data     <= mtr_r ? mem_read_data : mem_address;
          end else if (timeout_s) begin
            state_r     <= IDLE;
            mem_request <= 1'b0;
            wb_valid    <= 1'b1;
            bus_error   <= 1'b1;
          end else begin
            count_r <= count_r + COUNTER_WIDTH'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          mem_request <= 1'b0;
        end
      endcase
    end
  end

endmodule
